// File: rtl/sid_audio_mixer_dac_pkg.sv
// Shared widths, FSM state encoding and helpers for the SID audio mixer/DAC slice.
package sid_audio_mixer_dac_pkg;

  localparam int SID_VOICE_W    = 8;
  localparam int SID_NUM_VOICES = 3;
  localparam int SID_VOL_W      = 4;
  localparam int SID_SUM_W      = 10;  // 3 x 255 = 765 fits without overflow
  localparam int SID_PROD_W     = 14;  // 765 x 15 = 11475 fits without overflow

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUM  = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_MUL3 = 3'd4,
    ST_MUL4 = 3'd5
  } mix_state_e;

  // Widened contribution of one voice to the mix, or zero when muted.
  function automatic logic [SID_SUM_W-1:0] voice_term(input logic [SID_VOICE_W-1:0] v,
                                                     input logic                   mute);
    return mute ? '0 : SID_SUM_W'(v);
  endfunction

endpackage

// File: rtl/sid_pwm_modulator.sv
// Frame counter, duty reload/strobe and 1-bit output stage.
// Build macro SID_MIXER_DELTA_SIGMA_EN selects first-order delta-sigma instead of PWM.
module sid_pwm_modulator #(
  parameter int PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_next,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] sample,
  output logic                sample_strobe,
  output logic                audio_out
);

  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] sample_q, sample_d;
  logic                strobe_q, strobe_d;

  always_comb begin
    cnt_d    = cnt_q + CNT_ONE;
    // Reload on the last count so the new duty is live from the first count of the next frame.
    strobe_d = (cnt_q == CNT_MAX);
    sample_d = strobe_d ? duty_next : sample_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      cnt_q    <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef SID_MIXER_DELTA_SIGMA_EN
  // Carry of the accumulator is the output bit; pulse density is sample / 2^PWM_BITS.
  logic [PWM_BITS:0] acc_q, acc_d;

  always_comb acc_d = {1'b0, acc_q[PWM_BITS-1:0]} + {1'b0, sample_q};

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign audio_out = acc_q[PWM_BITS];
`else
  logic audio_q, audio_d;

  always_comb audio_d = (cnt_q < sample_q);

  always_ff @(posedge clk) begin
    if (rst) audio_q <= 1'b0;
    else     audio_q <= audio_d;
  end

  assign audio_out = audio_q;
`endif

  assign pwm_cnt       = cnt_q;
  assign sample        = sample_q;
  assign sample_strobe = strobe_q;

endmodule

// File: rtl/sid_audio_mixer_dac.sv
// Mixes three SID voices, scales by master volume with a 4-step shift-add multiplier,
// and drives the 1-bit audio modulator (PWM, or delta-sigma with SID_MIXER_DELTA_SIGMA_EN).
module sid_audio_mixer_dac
  import sid_audio_mixer_dac_pkg::*;
#(
  parameter int PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          voice0,
  input  logic [7:0]          voice1,
  input  logic [7:0]          voice2,
  input  logic [2:0]          voice_mute,
  input  logic [3:0]          volume,
  output logic                audio_out,
  output logic [PWM_BITS-1:0] sample,
  output logic                sample_strobe,
  output logic                busy
);

  mix_state_e                state_q, state_d;
  logic [SID_VOL_W-1:0]      vol_q, vol_d;
  logic [SID_PROD_W-1:0]     mcand_q, mcand_d;
  logic [SID_PROD_W-1:0]     product_q, product_d;
  logic [PWM_BITS-1:0]       duty_q, duty_d;
  logic                      busy_q, busy_d;
  logic [SID_SUM_W-1:0]      voice_sum;
  logic [PWM_BITS-1:0]       pwm_cnt;

  assign voice_sum = voice_term(voice0, voice_mute[0])
                   + voice_term(voice1, voice_mute[1])
                   + voice_term(voice2, voice_mute[2]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    vol_d     = vol_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    duty_d    = duty_q;

    case (state_q)
      ST_IDLE: if (pwm_cnt == '0) state_d = ST_SUM;
      ST_SUM: begin
        vol_d     = volume;
        mcand_d   = SID_PROD_W'(voice_sum);
        product_d = '0;
        state_d   = ST_MUL1;
      end
      ST_MUL1, ST_MUL2, ST_MUL3, ST_MUL4: begin
        // One volume bit per cycle, LSB first; the multiplicand doubles each step.
        if (vol_q[0]) product_d = product_q + mcand_q;
        mcand_d = mcand_q << 1;
        vol_d   = vol_q >> 1;
        if (state_q == ST_MUL4) begin
          duty_d  = product_d[SID_PROD_W-1 -: PWM_BITS];
          state_d = ST_IDLE;
        end else begin
          state_d = mix_state_e'(state_q + 3'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vol_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      duty_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vol_q     <= vol_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      duty_q    <= duty_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;

  sid_pwm_modulator #(
    .PWM_BITS (PWM_BITS)
  ) u_mod (
    .clk           (clk),
    .rst           (rst),
    .duty_next     (duty_q),
    .pwm_cnt       (pwm_cnt),
    .sample        (sample),
    .sample_strobe (sample_strobe),
    .audio_out     (audio_out)
  );

endmodule

// File: tb/tb_sid_audio_mixer_dac.sv
// Frame-level bench for sid_audio_mixer_dac: vector table, volume-change, reset and random frames.
module tb_sid_audio_mixer_dac;

  localparam int PWM_BITS = 10;
  localparam int FRAME    = 1 << PWM_BITS;

  typedef struct {
    logic [7:0] v0;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [2:0] mute;
    logic [3:0] vol;
    int         duty;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          voice0 = '0, voice1 = '0, voice2 = '0;
  logic [2:0]          voice_mute = '0;
  logic [3:0]          volume = '0;
  logic                audio_out;
  logic [PWM_BITS-1:0] sample;
  logic                sample_strobe;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int exp_cur = 0;  // duty the DUT should be modulating in the current frame

  vec_t tbl[10];

  sid_audio_mixer_dac #(.PWM_BITS(PWM_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .voice0        (voice0),
    .voice1        (voice1),
    .voice2        (voice2),
    .voice_mute    (voice_mute),
    .volume        (volume),
    .audio_out     (audio_out),
    .sample        (sample),
    .sample_strobe (sample_strobe),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Mix rule: sum of unmuted voices times volume, keeping the top PWM_BITS of a 14-bit product.
  function automatic int ref_duty(input vec_t v);
    int s = 0;
    if (!v.mute[0]) s += int'(v.v0);
    if (!v.mute[1]) s += int'(v.v1);
    if (!v.mute[2]) s += int'(v.v2);
    return (s * int'(v.vol)) / (1 << (14 - PWM_BITS));
  endfunction

  // Called #1 after the edge that starts a frame; returns #1 after the edge starting the next.
  task automatic run_frame(input vec_t v, input int chg_at, input logic [3:0] chg_vol,
                           input string tag);
    int highs = 0, strobe_bad = 0, busy_bad = 0, sample_bad = 0;
`ifdef SID_MIXER_DELTA_SIGMA_EN
    int pairs = 0;
    logic prev_a = 1'b0;
`endif
    voice0 = v.v0; voice1 = v.v1; voice2 = v.v2;
    voice_mute = v.mute; volume = v.vol;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk); #1;
      if (i == chg_at) volume = chg_vol;
      if (audio_out === 1'b1) highs++;
`ifdef SID_MIXER_DELTA_SIGMA_EN
      if (audio_out === 1'b1 && prev_a) pairs++;
      prev_a = (audio_out === 1'b1);
`endif
      if (sample_strobe !== (i == FRAME)) strobe_bad++;
      if (busy !== (i >= 1 && i <= 5)) busy_bad++;
      if (i < FRAME && sample !== PWM_BITS'(exp_cur)) sample_bad++;
    end
    check({tag, " audio high count"}, highs, exp_cur);
    check({tag, " strobe pattern errs"}, strobe_bad, 0);
    check({tag, " busy pattern errs"}, busy_bad, 0);
    check({tag, " sample held errs"}, sample_bad, 0);
`ifdef SID_MIXER_DELTA_SIGMA_EN
    if (exp_cur <= FRAME / 2) check({tag, " consecutive ones"}, pairs, 0);
`endif
    check({tag, " reloaded sample"}, 32'(sample), v.duty);
    exp_cur = v.duty;
  endtask

  initial begin
    vec_t rv;
    vec_t quiet;

    tbl[0] = '{8'd255, 8'd255, 8'd255, 3'b000, 4'd15, 717};
    tbl[1] = '{8'd128, 8'd0,   8'd0,   3'b000, 4'd8,  64};
    tbl[2] = '{8'd128, 8'd0,   8'd0,   3'b001, 4'd8,  0};
    tbl[3] = '{8'd255, 8'd255, 8'd2,   3'b000, 4'd8,  256};
    tbl[4] = '{8'd255, 8'd255, 8'd255, 3'b111, 4'd15, 0};
    tbl[5] = '{8'd255, 8'd255, 8'd255, 3'b000, 4'd0,  0};
    tbl[6] = '{8'd100, 8'd50,  8'd25,  3'b010, 4'd5,  39};
    tbl[7] = '{8'd200, 8'd0,   8'd200, 3'b000, 4'd15, 375};
    tbl[8] = '{8'd10,  8'd20,  8'd30,  3'b000, 4'd1,  3};
    tbl[9] = '{8'd255, 8'd0,   8'd0,   3'b110, 4'd15, 239};
    quiet  = '{8'd255, 8'd255, 8'd255, 3'b000, 4'd0,  0};

    // Reset for 3 clocks; the last reset edge begins frame 0.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset sample", 32'(sample), 0);
    check("reset audio_out", 32'(audio_out), 0);
    check("reset strobe", 32'(sample_strobe), 0);
    check("reset busy", 32'(busy), 0);
    exp_cur = 0;

    // Table-driven frames; each row's duty appears one frame after it is applied.
    for (int r = 0; r < 10; r++) run_frame(tbl[r], -1, 4'd0, $sformatf("vec%0d", r));

    // Volume drops at pwm_cnt=3: ignored this frame, silence two frame starts later.
    run_frame(tbl[0], 3, 4'd0, "volchg");
    run_frame(quiet, -1, 4'd0, "volchg_next");
    run_frame(tbl[0], -1, 4'd0, "volchg_recover");

    // Reset hits in MUL2 of a frame that is modulating a nonzero duty.
    voice0 = 8'd255; voice1 = 8'd255; voice2 = 8'd255; voice_mute = 3'b000; volume = 4'd15;
    repeat (3) begin @(posedge clk); #1; end
    check("pre-reset busy in MUL2", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset busy", 32'(busy), 0);
    check("midreset sample", 32'(sample), 0);
    check("midreset audio_out", 32'(audio_out), 0);
    check("midreset strobe", 32'(sample_strobe), 0);
    rst = 1'b0;
    exp_cur = 0;
    run_frame(tbl[7], -1, 4'd0, "post_reset0");
    run_frame(tbl[1], -1, 4'd0, "post_reset1");

    // Random frames against the arithmetic model.
    for (int n = 0; n < 6; n++) begin
      rv.v0   = 8'($urandom_range(0, 255));
      rv.v1   = 8'($urandom_range(0, 255));
      rv.v2   = 8'($urandom_range(0, 255));
      rv.mute = 3'($urandom_range(0, 7));
      rv.vol  = 4'($urandom_range(0, 15));
      rv.duty = ref_duty(rv);
      run_frame(rv, -1, 4'd0, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
